cnt_seq: RTL

- Load/enable sequencer that sits directly upstream of the 4-bit synchronous presettable counter (cnt).
- Drives the counter's P, PE, CET and CEP, and consumes its TC feedback.
- Runs a programmed list of preset values: load value, count to terminal count, load next value. Each list entry is one segment, so the counter acts as a programmable multi-interval timer.
- Software/testbench side uses a simple start/busy/done handshake.

---
 rtl/cnt_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/cnt_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_seq : load/enable sequencer driving a 4-bit presettable counter through
//           a programmed list of preset values (multi-interval timer).
// Optional: CNT_SEQ_LOOP_EN adds a 'loop' input that restarts the list.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module cnt_seq #(
  parameter int WIDTH   = 4,
  parameter int ENTRIES = 4,
  parameter int AW      = 2
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             start,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW-1:0]    n_last,
  input  logic             TC,
`ifdef CNT_SEQ_LOOP_EN
  input  logic             loop,
`endif
  output logic [WIDTH-1:0] P,
  output logic             PE,
  output logic             CET,
  output logic             CEP,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    seg_idx,
  output logic [7:0]       seg_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] tbl [ENTRIES];
  logic             run_exit;
  logic             at_last;
  logic             loop_go;

  // TC while paused means the counter is parked on 15, not wrapping.
  assign run_exit = (state == S_RUN) && TC && !pause;
  assign at_last  = (seg_idx == n_last);

`ifdef CNT_SEQ_LOOP_EN
  assign loop_go = loop;
`else
  assign loop_go = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (MR) begin
      state   <= S_IDLE;
      seg_idx <= '0;
      seg_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && cfg_we) begin
        tbl[cfg_addr] <= cfg_data;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            seg_idx <= '0;
            seg_cnt <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (run_exit) begin
            if (seg_cnt != 8'hFF) begin
              seg_cnt <= seg_cnt + 8'd1;
            end
            if (at_last && !loop_go) begin
              state <= S_DONE;
            end else begin
              seg_idx <= at_last ? '0 : seg_idx + 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Table is frozen while busy, so P stays constant through a segment.
  assign P    = (state == S_LOAD || state == S_RUN) ? tbl[seg_idx] : '0;
  assign PE   = (state != S_LOAD);
  assign CET  = (state == S_RUN);
  assign CEP  = (state == S_RUN) && !pause;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire
